fetch_unit: RTL

Instruction-fetch front end for the single-cycle MIPS core. It owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake. It latches the returned word and presents the decoded fields (op_c, funct, register indices, immediate, jump index) to the control decoder and datapath. It consumes the decoder's 3-bit next-PC select {jr, j, branch} to compute the next fetch address.

---
 rtl/fetch_unit_pkg.sv | 39 +++
 rtl/fetch_unit_pc_next_calc.sv | 41 ++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the MIPS fetch front end: next-PC select bits,
// instruction field positions, FSM state encoding and the default reset PC.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int PCN_BRANCH = 0;
    localparam int PCN_J      = 1;
    localparam int PCN_JR     = 2;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int JA_HI  = 25;
    localparam int JA_LO  = 0;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_t;

    function automatic logic isMisaligned(input logic [1:0] lsbs);
        return |lsbs;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC selection for the fetch unit.
// Priority is jr over j over branch over the sequential pc+4.
module pc_next_calc
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [2:0]        pc_next_c,
    input  logic [31:0]       imm_ext,
    input  logic [31:0]       rs_val,
    input  logic [25:0]       jaddr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    logic [31:0]       w_immShift;
    logic [ADDR_W-1:0] w_branchTarget;
    logic [ADDR_W-1:0] w_jumpTarget;
    logic [ADDR_W-1:0] w_regTarget;

    // Branch offset is a word count, so the sum wraps naturally at the PC width.
    assign w_immShift     = imm_ext << 2;
    assign w_branchTarget = pc_plus4 + ADDR_W'(w_immShift);
    assign w_jumpTarget   = {pc_plus4[ADDR_W-1:28], jaddr, 2'b00};
    assign w_regTarget    = ADDR_W'(rs_val);

    always_comb begin
        next_pc = pc_plus4;
        if (pc_next_c[PCN_JR]) begin
            next_pc = w_regTarget;
        end else if (pc_next_c[PCN_J]) begin
            next_pc = w_jumpTarget;
        end else if (pc_next_c[PCN_BRANCH]) begin
            next_pc = w_branchTarget;
        end
    end

    assign misalign = isMisaligned(next_pc[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over
// req/gnt/rvalid, holds it in IR and exposes the decoded fields to the core.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic [2:0]        pc_next_c,
    input  logic [31:0]       imm_ext,
    input  logic [31:0]       rs_val,
    output logic [5:0]        op_c,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic [25:0]       jaddr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_req;
    logic              r_valid;
    logic              r_err;

    logic [ADDR_W-1:0] w_pcPlus4;
    logic [ADDR_W-1:0] w_nextPc;
    logic              w_misalign;

    assign w_pcPlus4 = r_pc + ADDR_W'(4);

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pcNext (
        .pc_plus4  (w_pcPlus4),
        .pc_next_c (pc_next_c),
        .imm_ext   (imm_ext),
        .rs_val    (rs_val),
        .jaddr     (r_ir[JA_HI:JA_LO]),
        .next_pc   (w_nextPc),
        .misalign  (w_misalign)
    );

    // The request is raised one cycle after entering REQ from reset, so no
    // request is ever visible while reset is held. Responses outside WAIT are
    // dropped, which also discards data belonging to an aborted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_ir    <= 32'h0000_0000;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (imem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        r_ir    <= imem_rdata;
                        r_valid <= 1'b1;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (instr_ready) begin
                        r_pc    <= w_nextPc;
                        r_valid <= 1'b0;
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_state <= ST_HALT;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;
    assign pc          = r_pc;
    assign pc_plus4    = w_pcPlus4;

    assign op_c  = r_ir[OP_HI:OP_LO];
    assign rs    = r_ir[RS_HI:RS_LO];
    assign rt    = r_ir[RT_HI:RT_LO];
    assign rd    = r_ir[RD_HI:RD_LO];
    assign shamt = r_ir[SH_HI:SH_LO];
    assign funct = r_ir[FN_HI:FN_LO];
    assign imm16 = r_ir[IMM_HI:IMM_LO];
    assign jaddr = r_ir[JA_HI:JA_LO];

endmodule
